bus_arb_mux: RTL and testbench

Parametrised successor to the 8-bit 2:1 data-bus mux. Selects one of NUM_IN request channels of WIDTH bits each, using fixed-priority or round-robin arbitration. The winning word is captured into a single-entry output register with a valid/ready handshake. It sits between multiple internal data-bus sources (ALU, register file, memory read latch, PPU/APU readback) and the shared CPU data bus.

---
 rtl/bus_pkg.sv | 22 ++
 rtl/bus_arb_mux_rr_arbiter.sv | 48 ++++
 rtl/bus_arb_mux.sv | 111 +++++++++++
 tb/tb_bus_arb_mux.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the bus arbitration mux family.
//   ARB_FIXED / ARB_RR : values of the arbitration 'mode' input
//   clog2_sel()        : width of a channel index for n channels (minimum 1)
// -----------------------------------------------------------------------------
package bus_pkg;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

  // Constant-evaluable ceil(log2(n)), clamped to at least one bit.
  function automatic int clog2_sel(input int n);
    int r;
    r = 1;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bus_arb_mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational arbiter. Searches req upward from 'start' (wrapping at
// NUM_IN-1) in round-robin mode, or from index 0 in fixed-priority mode.
// Ports:
//   req       in  NUM_IN  request vector
//   start     in  SEL_W   first index searched in round-robin mode
//   mode      in  1       ARB_FIXED / ARB_RR
//   grant     out NUM_IN  one-hot grant (zero when no request)
//   idx       out SEL_W   encoded index of the grant (0 when none)
//   any_grant out 1       at least one request was granted
// -----------------------------------------------------------------------------
module rr_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int SEL_W  = clog2_sel(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  start,
  input  logic              mode,
  output logic [NUM_IN-1:0] grant,
  output logic [SEL_W-1:0]  idx,
  output logic              any_grant
);

  int w_start;
  int w_pos;

  // Fixed priority is just round-robin starting at channel 0.
  always_comb begin
    grant     = '0;
    idx       = '0;
    any_grant = 1'b0;
    w_pos     = 0;
    w_start   = (mode == ARB_RR) ? (int'(start) % NUM_IN) : 0;
    for (int i = 0; i < NUM_IN; i++) begin
      w_pos = w_start + i;
      if (w_pos >= NUM_IN) w_pos = w_pos - NUM_IN;
      if (!any_grant && req[w_pos]) begin
        any_grant    = 1'b1;
        grant[w_pos] = 1'b1;
        idx          = SEL_W'(w_pos);
      end
    end
  end

endmodule

// File: rtl/bus_arb_mux.sv
// -----------------------------------------------------------------------------
// bus_arb_mux
// NUM_IN-to-1 arbitrated data-bus mux with a single-entry registered output
// and valid/ready handshakes on both sides. Round-robin pointer advances past
// every granted channel in both arbitration modes.
// Optional feature macro: BUS_ARB_MUX_FORCE_EN (adds force_en / force_sel,
// restricting eligibility to one selected channel).
// Ports:
//   clk, rst   clock (rising edge), asynchronous active-high reset
//   mode       0 = fixed priority (lowest index), 1 = round-robin
//   in_valid   per-channel request
//   in_data    channel k at [k*WIDTH +: WIDTH]
//   in_ready   one-hot/zero accept strobe
//   out_valid  output register holds a word
//   out_data   registered word
//   out_src    channel index that supplied out_data
//   out_ready  consumer accept
//   force_en, force_sel (BUS_ARB_MUX_FORCE_EN only)
// -----------------------------------------------------------------------------
module bus_arb_mux
  import bus_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = clog2_sel(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
`ifdef BUS_ARB_MUX_FORCE_EN
  input  logic                    force_en,
  input  logic [SEL_W-1:0]        force_sel,
`endif
  input  logic                    out_ready
);

  logic              r_out_valid;
  logic [WIDTH-1:0]  r_out_data;
  logic [SEL_W-1:0]  r_out_src;
  logic [SEL_W-1:0]  r_rr_ptr;

  logic [NUM_IN-1:0] w_eligible;
  logic [NUM_IN-1:0] w_req;
  logic [NUM_IN-1:0] w_grant;
  logic [SEL_W-1:0]  w_idx;
  logic              w_any;
  logic              w_can_load;
  logic              w_load;
  logic [SEL_W-1:0]  w_ptr_next;

`ifdef BUS_ARB_MUX_FORCE_EN
  // A force_sel outside the channel range matches nothing, so no grant.
  always_comb begin
    w_eligible = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      w_eligible[k] = !force_en || (force_sel == SEL_W'(k));
    end
  end
`else
  assign w_eligible = '1;
`endif

  assign w_req = in_valid & w_eligible;

  rr_arbiter #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_arb (
    .req       (w_req),
    .start     (r_rr_ptr),
    .mode      (mode),
    .grant     (w_grant),
    .idx       (w_idx),
    .any_grant (w_any)
  );

  // Register is loadable when empty or draining this cycle.
  assign w_can_load = !r_out_valid || out_ready;
  assign w_load     = w_can_load && w_any;
  // in_ready is held low while reset is asserted.
  assign in_ready   = (w_can_load && !rst) ? w_grant : '0;

  assign w_ptr_next = (w_idx == SEL_W'(NUM_IN - 1)) ? '0 : (w_idx + SEL_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_rr_ptr    <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= in_data[int'(w_idx)*WIDTH +: WIDTH];
      r_out_src   <= w_idx;
      r_rr_ptr    <= w_ptr_next;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule

// File: tb/tb_bus_arb_mux.sv
module tb_bus_arb_mux;

  localparam int WIDTH  = 8;
  localparam int NUM_IN = 4;
  localparam int SEL_W  = 2;

  logic                    clk;
  logic                    rst;
  logic                    mode;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_src;
  logic                    out_ready;
  logic                    f_en;
  logic [SEL_W-1:0]        f_sel;

  bus_arb_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
`ifdef BUS_ARB_MUX_FORCE_EN
    .force_en  (f_en),
    .force_sel (f_sel),
`endif
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int         m_valid;
  logic [7:0] m_data;
  int         m_src;
  int         m_ptr;

  // Last sampled DUT values
  logic [3:0] s_ready;
  logic       s_valid;
  logic [7:0] s_data;
  int         s_src;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Winner = eligible requester with the smallest priority distance:
  // its index in fixed mode, its upward distance from the pointer in RR mode.
  function automatic int ref_grant(input logic md, input logic [3:0] v, input int ptr);
    int best, bestd, d;
    best  = -1;
    bestd = NUM_IN;
    for (int k = 0; k < NUM_IN; k++) begin
      if (v[k] && (!f_en || int'(f_sel) == k)) begin
        d = md ? ((k - ptr + NUM_IN) % NUM_IN) : k;
        if (d < bestd) begin
          bestd = d;
          best  = k;
        end
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_data  = 8'h00;
    m_src   = 0;
    m_ptr   = 0;
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic run_cycle(input logic md, input logic [3:0] v, input logic [31:0] d,
                           input logic rdy);
    int g, can, exp_rdy;
    mode      = md;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    #1;
    g       = ref_grant(md, v, m_ptr);
    can     = (m_valid == 0) || rdy;
    exp_rdy = (can != 0 && g >= 0) ? (1 << g) : 0;
    s_ready = in_ready;
    check("in_ready", int'(in_ready), exp_rdy);
    @(posedge clk);
    if (can != 0 && g >= 0) begin
      m_valid = 1;
      m_data  = d[g*8 +: 8];
      m_src   = g;
      m_ptr   = (g + 1) % NUM_IN;
    end else if (m_valid != 0 && rdy) begin
      m_valid = 0;
    end
    #1;
    s_valid = out_valid;
    s_data  = out_data;
    s_src   = int'(out_src);
    check("out_valid", int'(out_valid), m_valid);
    if (m_valid != 0) begin
      check("out_data", int'(out_data), int'(m_data));
      check("out_src", int'(out_src), m_src);
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic        md;
    logic [3:0]  v;
    logic [31:0] d;
    logic        rdy;
    logic [3:0]  e_rdy;
    logic        e_vld;
    int          e_src;
    logic [7:0]  e_data;
  } vec_t;

  vec_t tbl[14];

  logic [7:0] held;

  initial begin
    rst       = 1'b1;
    mode      = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    f_en      = 1'b0;
    f_sel     = '0;
    model_reset();

    tbl[0]  = '{1'b0, 4'b1010, 32'h3300_1100, 1'b1, 4'b0010, 1'b1, 1, 8'h11};
    tbl[1]  = '{1'b1, 4'b1111, 32'hD3C2_B1A0, 1'b1, 4'b0100, 1'b1, 2, 8'hC2};
    tbl[2]  = '{1'b1, 4'b1111, 32'hD3C2_B1A0, 1'b1, 4'b1000, 1'b1, 3, 8'hD3};
    tbl[3]  = '{1'b1, 4'b1111, 32'hD3C2_B1A0, 1'b1, 4'b0001, 1'b1, 0, 8'hA0};
    tbl[4]  = '{1'b1, 4'b1111, 32'hD3C2_B1A0, 1'b1, 4'b0010, 1'b1, 1, 8'hB1};
    tbl[5]  = '{1'b1, 4'b1111, 32'hD3C2_B1A0, 1'b0, 4'b0000, 1'b1, 1, 8'hB1};
    tbl[6]  = '{1'b1, 4'b1111, 32'hD3C2_B1A0, 1'b0, 4'b0000, 1'b1, 1, 8'hB1};
    tbl[7]  = '{1'b1, 4'b0000, 32'hD3C2_B1A0, 1'b1, 4'b0000, 1'b0, 1, 8'hB1};
    tbl[8]  = '{1'b1, 4'b0000, 32'hD3C2_B1A0, 1'b0, 4'b0000, 1'b0, 1, 8'hB1};
    tbl[9]  = '{1'b1, 4'b0100, 32'hD3C2_B1A0, 1'b1, 4'b0100, 1'b1, 2, 8'hC2};
    tbl[10] = '{1'b1, 4'b0010, 32'hD3C2_B1A0, 1'b1, 4'b0010, 1'b1, 1, 8'hB1};
    tbl[11] = '{1'b1, 4'b0001, 32'hD3C2_B1A0, 1'b1, 4'b0001, 1'b1, 0, 8'hA0};
    tbl[12] = '{1'b0, 4'b1100, 32'hD3C2_B1A0, 1'b1, 4'b0100, 1'b1, 2, 8'hC2};
    tbl[13] = '{1'b1, 4'b1001, 32'hD3C2_B1A0, 1'b1, 4'b1000, 1'b1, 3, 8'hD3};

    // Reset values
    #2;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_src", int'(out_src), 0);
    check("rst_in_ready", int'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 14; i++) begin
      run_cycle(tbl[i].md, tbl[i].v, tbl[i].d, tbl[i].rdy);
      check($sformatf("tbl%0d_in_ready", i), int'(s_ready), int'(tbl[i].e_rdy));
      check($sformatf("tbl%0d_out_valid", i), int'(s_valid), int'(tbl[i].e_vld));
      check($sformatf("tbl%0d_out_src", i), s_src, tbl[i].e_src);
      check($sformatf("tbl%0d_out_data", i), int'(s_data), int'(tbl[i].e_data));
    end

    // Back-pressure for three cycles, then simultaneous drain and load
    run_cycle(1'b1, 4'b1111, 32'h4433_2211, 1'b1);
    held = s_data;
    for (int i = 0; i < 3; i++) begin
      run_cycle(1'b1, 4'b1111, 32'h8877_6655, 1'b0);
      check("bp_in_ready_zero", int'(s_ready), 0);
      check("bp_data_stable", int'(s_data), int'(held));
    end
    run_cycle(1'b1, 4'b1111, 32'h8877_6655, 1'b1);
    check("bp_release_grant", int'(s_ready != 4'b0000), 1);
    check("bp_release_valid", int'(s_valid), 1);

    // Asynchronous reset while holding a word
    run_cycle(1'b1, 4'b1111, 32'hCAFE_BABE, 1'b0);
    check("pre_reset_valid", int'(s_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", int'(out_valid), 0);
    check("async_rst_out_data", int'(out_data), 0);
    check("async_rst_out_src", int'(out_src), 0);
    check("async_rst_in_ready", int'(in_ready), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    run_cycle(1'b1, 4'b1111, 32'h0403_0201, 1'b1);
    check("post_rst_grant", int'(s_ready), 1);
    check("post_rst_src", s_src, 0);
    check("post_rst_data", int'(s_data), 8'h01);

    // Round-robin starvation bound with all channels requesting
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < NUM_IN; i++) begin
        run_cycle(1'b1, 4'b1111, $urandom, 1'b1);
        seen = seen | (1 << s_src);
      end
      check("rr_all_served", seen, 4'hF);
    end

`ifdef BUS_ARB_MUX_FORCE_EN
    f_en  = 1'b1;
    f_sel = 2'd2;
    for (int i = 0; i < 4; i++) begin
      run_cycle(1'b1, 4'b1111, $urandom, 1'b1);
      check("force_src", s_src, 2);
    end
    for (int i = 0; i < 256; i++) begin
      logic [31:0] d;
      d = $urandom;
      d[23:16] = 8'(i);
      run_cycle(1'(i & 1), 4'b1111, d, 1'b1);
      check("force_sweep_data", int'(s_data), i);
    end
    f_en = 1'b0;
`endif

    // Randomized traffic against the reference model
    for (int i = 0; i < 2000; i++) begin
      run_cycle(1'($urandom_range(0, 3) != 0), 4'($urandom), $urandom,
                1'($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
